// File: rtl/uart_trx_agent.sv
// uart_trx_agent: parametrised UART transceiver with configurable frame format,
// false-start rejection, per-byte parity/framing flags, RX FIFO and echo mode.
module uart_trx_agent #(
  parameter int CLKS_PER_BIT = 5207,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst,
  input  logic                            rx,
  output logic                            tx,
  input  logic                            tx_en,
  input  logic [DATA_BITS-1:0]            tx_data,
  output logic                            tx_busy,
  output logic                            tx_done,
  input  logic                            echo,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            rx_perr,
  output logic                            rx_ferr,
  output logic                            rx_valid,
  input  logic                            rx_rd,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
  output logic                            rx_ovf,
  input  logic                            ovf_clr
);

  localparam int CW = $clog2(CLKS_PER_BIT + 2);
  localparam int BW = $clog2(DATA_BITS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = DATA_BITS + 2;

  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LOAD = (STOP_BITS == 2);
  localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);

  // Parity bit that goes with a data word: XOR for even, XNOR for odd.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    parity_of = (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_e;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_e;

  // ---------------------------------------------------------------- signals
  tx_state_e             tx_state_q, tx_state_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]         tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]  tx_sh_q, tx_sh_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_stop_q, tx_stop_d;
  logic                  tx_q, tx_d;
  logic                  tx_done_q, tx_done_d;
  logic                  echo_take;

  logic                  rx_meta_q, rxs_q;
  rx_state_e             rx_state_q, rx_state_d;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]         rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]  rx_sh_q, rx_sh_d;
  logic                  rx_perr_q, rx_perr_d;
  logic                  rx_ferr_q, rx_ferr_d;
  logic                  rx_stop_q, rx_stop_d;
  logic                  rx_push;
  logic [WW-1:0]         rx_word;

  logic [WW-1:0]         fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [WW-1:0]         head;
  logic                  fifo_valid, fifo_full, pop, push_ok;

  assign head       = fifo_mem_q[rd_ptr_q];
  assign fifo_valid = (count_q != '0);
  assign fifo_full  = (count_q == FULL_CNT);

  // ------------------------------------------------------------- transmit
  // TX state register; reset forces the line idle immediately.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_stop_q  <= 1'b0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_stop_q  <= tx_stop_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // TX next state; the line level is registered from the next state so tx is glitch-free.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_stop_d  = tx_stop_q;
    tx_done_d  = 1'b0;
    echo_take  = 1'b0;
    tx_d       = 1'b1;
    case (tx_state_q)
      T_IDLE: begin
        if (echo) begin
          if (fifo_valid) begin
            echo_take  = 1'b1;
            tx_state_d = T_START;
            tx_cnt_d   = BIT_LOAD;
            tx_sh_d    = head[DATA_BITS-1:0];
            tx_par_d   = parity_of(head[DATA_BITS-1:0]);
          end
        end else if (tx_en) begin
          tx_state_d = T_START;
          tx_cnt_d   = BIT_LOAD;
          tx_sh_d    = tx_data;
          tx_par_d   = parity_of(tx_data);
        end
      end
      T_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = T_DATA;
          tx_cnt_d   = BIT_LOAD;
          tx_bit_d   = LAST_BIT;
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      T_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = BIT_LOAD;
          tx_sh_d  = tx_sh_q >> 1;
          if (tx_bit_q == '0) begin
            tx_state_d = (PARITY != 0) ? T_PAR : T_STOP;
            tx_stop_d  = STOP_LOAD;
          end else begin
            tx_bit_d = tx_bit_q - 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      T_PAR: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = T_STOP;
          tx_cnt_d   = BIT_LOAD;
          tx_stop_d  = STOP_LOAD;
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      T_STOP: begin
        if (tx_cnt_q == '0) begin
          if (!tx_stop_q) begin
            tx_state_d = T_IDLE;
            tx_done_d  = 1'b1;
          end else begin
            tx_stop_d = 1'b0;
            tx_cnt_d  = BIT_LOAD;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase

    case (tx_state_d)
      T_START: tx_d = 1'b0;
      T_DATA:  tx_d = tx_sh_d[0];
      T_PAR:   tx_d = tx_par_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = (tx_state_q != T_IDLE);
  assign tx_done = tx_done_q;

  // -------------------------------------------------------------- receive
  // Two-flop synchroniser for the asynchronous serial input, idle high.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // RX state register; reset discards any partial frame.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_stop_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_stop_q  <= rx_stop_d;
    end
  end

  // RX next state: half-bit wait to the start-bit centre, then one sample per bit period.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_stop_d  = rx_stop_q;
    rx_push    = 1'b0;
    rx_word    = '0;
    case (rx_state_q)
      R_IDLE: begin
        if (!rxs_q) begin
          rx_state_d = R_START;
          rx_cnt_d   = HALF_LOAD;
          rx_bit_d   = LAST_BIT;
        end
      end
      R_START: begin
        if (rx_cnt_q == '0) begin
          if (rxs_q) begin
            rx_state_d = R_IDLE;
          end else begin
            rx_state_d = R_DATA;
            rx_cnt_d   = BIT_LOAD;
            rx_perr_d  = 1'b0;
            rx_ferr_d  = 1'b0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      R_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d = BIT_LOAD;
          rx_sh_d  = {rxs_q, rx_sh_q[DATA_BITS-1:1]};
          if (rx_bit_q == '0) begin
            rx_state_d = (PARITY != 0) ? R_PAR : R_STOP;
            rx_stop_d  = STOP_LOAD;
          end else begin
            rx_bit_d = rx_bit_q - 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      R_PAR: begin
        if (rx_cnt_q == '0) begin
          rx_perr_d  = rxs_q ^ parity_of(rx_sh_q);
          rx_state_d = R_STOP;
          rx_cnt_d   = BIT_LOAD;
          rx_stop_d  = STOP_LOAD;
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      R_STOP: begin
        if (rx_cnt_q == '0) begin
          if (!rx_stop_q) begin
            // Store errored frames too; go idle now so the next start bit is not missed.
            rx_push    = 1'b1;
            rx_word    = {rx_ferr_q | ~rxs_q, rx_perr_q, rx_sh_q};
            rx_state_d = R_IDLE;
          end else begin
            rx_ferr_d = rx_ferr_q | ~rxs_q;
            rx_stop_d = 1'b0;
            rx_cnt_d  = BIT_LOAD;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- FIFO
  // Pointer/occupancy update; a push into a full FIFO survives only if a pop frees a slot.
  always_comb begin
    pop      = echo ? echo_take : (rx_rd & fifo_valid);
    push_ok  = rx_push & (~fifo_full | pop);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + NW'(push_ok) - NW'(pop);
    ovf_d    = (rx_push & fifo_full & ~pop) | (ovf_q & ~ovf_clr);
  end

  // FIFO control registers.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are don't-care while count is zero, so no reset.
  always_ff @(posedge sys_clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= rx_word;
  end

  assign rx_valid = fifo_valid;
  assign rx_count = count_q;
  assign rx_ovf   = ovf_q;
  assign rx_data  = fifo_valid ? head[DATA_BITS-1:0] : '0;
  assign rx_perr  = fifo_valid & head[DATA_BITS];
  assign rx_ferr  = fifo_valid & head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_trx_agent.sv
// Bench for uart_trx_agent: CLKS_PER_BIT=15, 8 data bits, even parity, 2 stop bits, 4-deep FIFO.
module tb_uart_trx_agent;

  localparam int BITP  = 16;
  localparam int NBITS = 12;
  localparam int FRAME = NBITS * BITP;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       rx = 1'b1;
  logic       tx;
  logic       tx_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_busy;
  logic       tx_done;
  logic       echo = 1'b0;
  logic [7:0] rx_data;
  logic       rx_perr;
  logic       rx_ferr;
  logic       rx_valid;
  logic       rx_rd = 1'b0;
  logic [2:0] rx_count;
  logic       rx_ovf;
  logic       ovf_clr = 1'b0;

  int errors  = 0;
  int checks  = 0;
  int push_at = -1;

  logic [7:0]  mon_q[$];
  bit          mon_en = 1'b0;
  int          mon_bad = 0;
  logic [11:0] mon_f;

  uart_trx_agent #(
    .CLKS_PER_BIT(15), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx(rx), .tx(tx), .tx_en(tx_en),
    .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done), .echo(echo),
    .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_valid(rx_valid),
    .rx_rd(rx_rd), .rx_count(rx_count), .rx_ovf(rx_ovf), .ovf_clr(ovf_clr)
  );

  always #5 sys_clk = ~sys_clk;

  // Checker UART on the DUT tx line: samples every bit centre of a 12-bit frame.
  always begin
    @(negedge tx);
    if (mon_en) begin
      for (int b = 0; b < NBITS; b++) begin
        repeat (b == 0 ? BITP / 2 : BITP) @(posedge sys_clk);
        #1;
        mon_f[b] = tx;
      end
      if (mon_f[0] == 1'b0 && mon_f[9] == ^mon_f[8:1] && mon_f[11:10] == 2'b11)
        mon_q.push_back(mon_f[8:1]);
      else
        mon_bad++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic pop_one();
    rx_rd = 1'b1;
    step(1);
    rx_rd = 1'b0;
  endtask

  // Drives one frame on rx (start, 8 data LSB first, even parity, 2 stops), then idle.
  // rd_cycle pulses rx_rd; ovf_at reports the first cycle rx_ovf is seen high.
  task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit bad_stop2,
                            input int idle, input int rd_cycle, output int ovf_at);
    logic [11:0] bits;
    bits   = {~bad_stop2, 1'b1, (^d) ^ flip_par, d, 1'b0};
    ovf_at = -1;
    for (int c = 0; c < FRAME + idle; c++) begin
      rx    = (c < FRAME) ? bits[c / BITP] : 1'b1;
      rx_rd = (c == rd_cycle);
      if (ovf_at < 0 && rx_ovf) ovf_at = c;
      step(1);
    end
    rx_rd = 1'b0;
    rx    = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b0;
    step(3);
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
    checks++; if (tx_done !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b exp=0", tx_done); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", rx_count); end
    checks++; if (rx_ovf !== 1'b0)   begin errors++; $display("FAIL reset_ovf got=%b exp=0", rx_ovf); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    checks++; if (rx_perr !== 1'b0 || rx_ferr !== 1'b0)
      begin errors++; $display("FAIL reset_flags got=%b%b exp=00", rx_perr, rx_ferr); end
    sys_rst = 1'b1;
    step(2);
  endtask

  task automatic test_tx(input logic [7:0] d, input logic [7:0] d2);
    logic [11:0] exp_bits;
    int done_cnt, done_at, g;
    exp_bits = {1'b1, 1'b1, ^d, d, 1'b0};
    tx_data = d;
    tx_en   = 1'b1;
    step(1);
    tx_en   = 1'b0;
    tx_data = ~d;
    done_cnt = 0;
    done_at  = -1;
    for (int c = 0; c <= FRAME; c++) begin
      if (c % BITP == BITP / 2 && c < FRAME) begin
        checks++;
        if (tx !== exp_bits[c / BITP])
          begin errors++; $display("FAIL tx_bit%0d got=%b exp=%b", c / BITP, tx, exp_bits[c / BITP]); end
        checks++;
        if (tx_busy !== 1'b1) begin errors++; $display("FAIL tx_busy_mid got=%b exp=1", tx_busy); end
      end
      if (tx_done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c == 40) tx_en = 1'b1;
      if (c == 41) tx_en = 1'b0;
      if (c == FRAME) begin
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL tx_busy_end got=%b exp=0", tx_busy); end
        tx_en   = 1'b1;
        tx_data = d2;
      end
      step(1);
    end
    tx_en = 1'b0;
    checks++;
    if (done_cnt != 1 || done_at != FRAME)
      begin errors++; $display("FAIL tx_done_pulse got=%0d@%0d exp=1@%0d", done_cnt, done_at, FRAME); end
    checks++;
    if (tx !== 1'b0 || tx_busy !== 1'b1)
      begin errors++; $display("FAIL tx_back_to_back got=tx%b/busy%b exp=tx0/busy1", tx, tx_busy); end
    for (g = 0; g < FRAME + 60; g++) begin
      if (tx_done) break;
      step(1);
    end
    checks++;
    if (g != FRAME) begin errors++; $display("FAIL tx_second_frame_len got=%0d exp=%0d", g, FRAME); end
    step(4);
  endtask

  task automatic test_rx();
    logic [7:0] d;
    bit flip, bad;
    int at;
    for (int i = 0; i < 6; i++) begin
      d    = (i < 3) ? 8'h3C : 8'($urandom);
      flip = (i == 1) || (i >= 3 && $urandom_range(0, 1) == 1);
      bad  = (i == 2) || (i >= 3 && $urandom_range(0, 1) == 1);
      send_frame(d, flip, bad, 40, -1, at);
      checks++;
      if (rx_count !== 3'd1) begin errors++; $display("FAIL rx_count case%0d got=%0d exp=1", i, rx_count); end
      checks++;
      if (rx_data !== d) begin errors++; $display("FAIL rx_data case%0d got=%h exp=%h", i, rx_data, d); end
      checks++;
      if (rx_perr !== flip) begin errors++; $display("FAIL rx_perr case%0d got=%b exp=%b", i, rx_perr, flip); end
      checks++;
      if (rx_ferr !== bad) begin errors++; $display("FAIL rx_ferr case%0d got=%b exp=%b", i, rx_ferr, bad); end
      pop_one();
      checks++;
      if (rx_count !== 3'd0 || rx_valid !== 1'b0)
        begin errors++; $display("FAIL rx_pop case%0d got=%0d/%b exp=0/0", i, rx_count, rx_valid); end
    end
  endtask

  task automatic test_false_start();
    logic [7:0] d;
    int at;
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(40);
    checks++;
    if (rx_count !== 3'd0 || rx_valid !== 1'b0 || rx_ovf !== 1'b0)
      begin errors++; $display("FAIL false_start got=%0d/%b/%b exp=0/0/0", rx_count, rx_valid, rx_ovf); end
    d = 8'($urandom);
    send_frame(d, 1'b0, 1'b0, 40, -1, at);
    checks++;
    if (rx_count !== 3'd1 || rx_data !== d || rx_perr !== 1'b0 || rx_ferr !== 1'b0)
      begin errors++; $display("FAIL after_false_start got=%0d/%h exp=1/%h", rx_count, rx_data, d); end
    pop_one();
  endtask

  task automatic test_overflow();
    logic [7:0] q[$];
    logic [7:0] d;
    bit ovf_m;
    int at;
    ovf_m = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send_frame(d, 1'b0, 1'b0, 8, -1, at);
      if (q.size() < 4) q.push_back(d);
      else begin
        ovf_m   = 1'b1;
        push_at = at;
      end
    end
    checks++;
    if (rx_count !== 3'(q.size())) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", rx_count, q.size()); end
    checks++;
    if (rx_ovf !== ovf_m) begin errors++; $display("FAIL ovf_set got=%b exp=%b", rx_ovf, ovf_m); end
    checks++;
    if (push_at < FRAME - 16 || push_at > FRAME + 7)
      begin errors++; $display("FAIL push_latency got=%0d exp=%0d..%0d", push_at, FRAME - 16, FRAME + 7); end
    while (q.size() > 0) begin
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== q[0])
        begin errors++; $display("FAIL ovf_read got=%b/%h exp=1/%h", rx_valid, rx_data, q[0]); end
      pop_one();
      void'(q.pop_front());
    end
    checks++;
    if (rx_count !== 3'd0 || rx_ovf !== 1'b1)
      begin errors++; $display("FAIL ovf_drained got=%0d/%b exp=0/1", rx_count, rx_ovf); end
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    checks++;
    if (rx_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", rx_ovf); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] q[$];
    logic [7:0] d;
    int at, rd_c;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      send_frame(d, 1'b0, 1'b0, 8, -1, at);
      q.push_back(d);
    end
    checks++;
    if (rx_count !== 3'd4 || rx_ovf !== 1'b0)
      begin errors++; $display("FAIL full_fill got=%0d/%b exp=4/0", rx_count, rx_ovf); end
    rd_c = ((push_at > 0) ? push_at : FRAME - 4) - 1;
    d = 8'($urandom);
    send_frame(d, 1'b0, 1'b0, 8, rd_c, at);
    void'(q.pop_front());
    q.push_back(d);
    checks++;
    if (rx_count !== 3'd4) begin errors++; $display("FAIL pushpop_count got=%0d exp=4", rx_count); end
    checks++;
    if (rx_ovf !== 1'b0) begin errors++; $display("FAIL pushpop_ovf got=%b exp=0", rx_ovf); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_data !== q[i]) begin errors++; $display("FAIL pushpop_order%0d got=%h exp=%h", i, rx_data, q[i]); end
      pop_one();
    end
  endtask

  task automatic test_echo();
    int at, g;
    mon_q.delete();
    mon_bad = 0;
    mon_en  = 1'b1;
    echo    = 1'b1;
    step(2);
    tx_en   = 1'b1;
    tx_data = 8'hFF;
    step(1);
    tx_en   = 1'b0;
    step(1);
    checks++;
    if (tx_busy !== 1'b0 || tx !== 1'b1)
      begin errors++; $display("FAIL echo_txen_ignored got=busy%b/tx%b exp=0/1", tx_busy, tx); end
    send_frame(8'h5A, 1'b0, 1'b0, 0, -1, at);
    send_frame(8'hC3, 1'b0, 1'b0, 0, -1, at);
    for (g = 0; g < 1500; g++) begin
      if (mon_q.size() >= 2 && !tx_busy) break;
      step(1);
    end
    checks++;
    if (g >= 1500) begin errors++; $display("FAIL echo_timeout got=%0d exp=2 bytes", mon_q.size()); end
    checks++;
    if (mon_q.size() != 2 || mon_bad != 0)
      begin errors++; $display("FAIL echo_frames got=%0d bad=%0d exp=2 bad=0", mon_q.size(), mon_bad); end
    else begin
      checks++;
      if (mon_q[0] !== 8'h5A) begin errors++; $display("FAIL echo_byte0 got=%h exp=5a", mon_q[0]); end
      checks++;
      if (mon_q[1] !== 8'hC3) begin errors++; $display("FAIL echo_byte1 got=%h exp=c3", mon_q[1]); end
    end
    checks++;
    if (rx_count !== 3'd0 || rx_valid !== 1'b0)
      begin errors++; $display("FAIL echo_fifo_empty got=%0d/%b exp=0/0", rx_count, rx_valid); end
  endtask

  task automatic test_reset_mid_echo();
    int at, g;
    mon_en = 1'b0;
    send_frame(8'h96, 1'b0, 1'b0, 0, -1, at);
    for (g = 0; g < 50; g++) begin
      if (tx_busy && tx == 1'b0) break;
      step(1);
    end
    checks++;
    if (g >= 50) begin errors++; $display("FAIL echo_start_timeout got=busy%b exp=busy1", tx_busy); end
    #2;
    sys_rst = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0)
      begin errors++; $display("FAIL async_reset_tx got=tx%b/busy%b exp=1/0", tx, tx_busy); end
    checks++;
    if (rx_count !== 3'd0 || rx_valid !== 1'b0)
      begin errors++; $display("FAIL async_reset_fifo got=%0d/%b exp=0/0", rx_count, rx_valid); end
    step(2);
    echo    = 1'b0;
    sys_rst = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset();
    test_tx(8'hA5, 8'($urandom));
    test_tx(8'($urandom), 8'($urandom));
    test_rx();
    test_false_start();
    test_overflow();
    test_push_pop_full();
    test_echo();
    test_reset_mid_echo();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
